// File: rtl/tt_extractor.sv
// tt_extractor: sweeps every minterm of an NIN-input function, samples f and returns the truth table.
// Optional macro TT_POPCOUNT_EN adds the ones output (count of minterms with f = 1).
module tt_extractor #(
  parameter int NIN    = 7,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [NIN-1:0]    x,
  input  logic              f,
  output logic [2**NIN-1:0] tt,
  output logic              tt_valid,
  input  logic              tt_ready
`ifdef TT_POPCOUNT_EN
  ,
  output logic [NIN:0]      ones
`endif
);

  localparam int TTW = 1 << NIN;
  localparam logic [NIN-1:0] X_LAST = NIN'(TTW - 1);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t         state_reg, state_next;
  logic [NIN-1:0] x_reg, x_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [TTW-1:0] tt_reg, tt_next;
`ifdef TT_POPCOUNT_EN
  logic [NIN:0]   ones_reg, ones_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      cnt_reg   <= '0;
      tt_reg    <= '0;
`ifdef TT_POPCOUNT_EN
      ones_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      cnt_reg   <= cnt_next;
      tt_reg    <= tt_next;
`ifdef TT_POPCOUNT_EN
      ones_reg  <= ones_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    cnt_next   = cnt_reg;
    tt_next    = tt_reg;
`ifdef TT_POPCOUNT_EN
    ones_next  = ones_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SWEEP;
          x_next     = '0;
          cnt_next   = SETTLE_CNT;
          tt_next    = '0;
`ifdef TT_POPCOUNT_EN
          ones_next  = '0;
`endif
        end
      end
      SWEEP: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          // last edge of this minterm's window: capture and advance
          tt_next[x_reg] = f;
`ifdef TT_POPCOUNT_EN
          ones_next = ones_reg + (NIN+1)'(f);
`endif
          cnt_next = SETTLE_CNT;
          if (x_reg == X_LAST) begin
            state_next = DONE;
            x_next     = '0;
          end else begin
            x_next = x_reg + NIN'(1);
          end
        end
      end
      DONE: begin
        if (tt_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign tt_valid = (state_reg == DONE);
  assign x        = x_reg;
  assign tt       = tt_reg;
`ifdef TT_POPCOUNT_EN
  assign ones     = ones_reg;
`endif

endmodule

// File: tb/tb_tt_extractor.sv
// Directed bench for tt_extractor: three instances (NIN=7/SETTLE=0, NIN=7/SETTLE=3, NIN=3/SETTLE=0).
module tb_tt_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // instance A: NIN=7, SETTLE=0, function chosen by fsel
  logic         start_a, busy_a, f_a, tt_valid_a, tt_ready_a;
  logic [6:0]   x_a;
  logic [127:0] tt_a;
  int           fsel;
  // instance B: NIN=7, SETTLE=3, f registered one cycle behind x
  logic         start_b, busy_b, f_b, tt_valid_b, tt_ready_b;
  logic [6:0]   x_b;
  logic [127:0] tt_b;
  // instance C: NIN=3, SETTLE=0, f = x0 & x1
  logic         start_c, busy_c, f_c, tt_valid_c, tt_ready_c;
  logic [2:0]   x_c;
  logic [7:0]   tt_c;
`ifdef TT_POPCOUNT_EN
  logic [7:0]   ones_a, ones_b;
  logic [3:0]   ones_c;
`endif

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic maj_chain(input logic [6:0] v);
    logic w0, w1, w2, w3;
    w0 = maj(v[2], v[3], v[4]);
    w1 = maj(v[5], v[6], w0);
    w2 = maj(v[0], v[1], w1);
    w3 = maj(v[2], v[3], w2);
    return maj(v[4], w2, w3);
  endfunction

  always_comb begin
    case (fsel)
      0:       f_a = 1'b0;
      1:       f_a = 1'b1;
      2:       f_a = x_a[0];
      3:       f_a = x_a[6];
      default: f_a = maj_chain(x_a);
    endcase
  end

  always_ff @(posedge clk) f_b <= x_b[0] ^ x_b[6];
  assign f_c = x_c[0] & x_c[1];

  tt_extractor #(.NIN(7), .SETTLE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .x(x_a), .f(f_a),
    .tt(tt_a), .tt_valid(tt_valid_a), .tt_ready(tt_ready_a)
`ifdef TT_POPCOUNT_EN
    , .ones(ones_a)
`endif
  );

  tt_extractor #(.NIN(7), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .x(x_b), .f(f_b),
    .tt(tt_b), .tt_valid(tt_valid_b), .tt_ready(tt_ready_b)
`ifdef TT_POPCOUNT_EN
    , .ones(ones_b)
`endif
  );

  tt_extractor #(.NIN(3), .SETTLE(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .x(x_c), .f(f_c),
    .tt(tt_c), .tt_valid(tt_valid_c), .tt_ready(tt_ready_c)
`ifdef TT_POPCOUNT_EN
    , .ones(ones_c)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One sweep on instance A with tt_ready held high (one-cycle DONE).
  task automatic sweep_a(input string tag, input logic [127:0] exp_tt, input int exp_ones);
    int n;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check({tag, "_busy_e0"}, 128'(busy_a), 128'(1));
    check({tag, "_tt_clr_e0"}, tt_a, 128'(0));
    n = 0;
    while (!tt_valid_a && n < 2000) begin
      @(negedge clk); n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(128));
    check({tag, "_tt"}, tt_a, exp_tt);
`ifdef TT_POPCOUNT_EN
    check({tag, "_ones"}, 128'(ones_a), 128'(exp_ones));
`else
    if (exp_ones < 0) $display("note: negative popcount expectation in %s", tag);
`endif
    @(negedge clk);
    check({tag, "_released"}, {125'(0), tt_valid_a, busy_a, |x_a}, 128'(0));
    check({tag, "_tt_kept"}, tt_a, exp_tt);
  endtask

  initial begin
    int n;
    logic [127:0] held;
    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    tt_ready_a = 1; tt_ready_b = 0; tt_ready_c = 1;
    fsel = 0;
    repeat (3) @(negedge clk);
    check("reset_a", {tt_a[124:0], busy_a, tt_valid_a, |x_a}, 128'(0));
    check("reset_b", {tt_b[124:0], busy_b, tt_valid_b, |x_b}, 128'(0));
    check("reset_c", {117'(0), tt_c, busy_c, tt_valid_c, |x_c}, 128'(0));
`ifdef TT_POPCOUNT_EN
    check("reset_ones", {ones_a, ones_b, 4'(ones_c)}, 128'(0));
`endif
    rst = 1'b0;

    fsel = 0; sweep_a("const0", 128'(0), 0);
    fsel = 1; sweep_a("const1", {128{1'b1}}, 128);
    fsel = 2; sweep_a("proj_x0", 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa, 64);
    fsel = 3; sweep_a("proj_x6", 128'hffffffffffffffff0000000000000000, 64);
    fsel = 4; sweep_a("maj_chain", 128'hfeeeeee0fee8e880fee8e880f8888880, 64);

    // reset at minterm 50 abandons the sweep
    fsel = 2;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (x_a != 7'd50 && n < 300) begin
      @(negedge clk); n++;
    end
    check("rst_reach_50", 128'(x_a), 128'(50));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_mid_ctrl", {125'(0), busy_a, tt_valid_a, |x_a}, 128'(0));
    check("rst_mid_tt", tt_a, 128'(0));
    sweep_a("after_rst", 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa, 64);

    // settle + backpressure + ignored starts on instance B
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (!tt_valid_b && n < 2000) begin
      @(negedge clk); n++;
      start_b = (n == 100);
    end
    start_b = 1'b0;
    check("b_latency", 128'(n), 128'(512));
    check("b_tt", tt_b, 128'h5555555555555555aaaaaaaaaaaaaaaa);
`ifdef TT_POPCOUNT_EN
    check("b_ones", 128'(ones_b), 128'(64));
`endif
    held = tt_b;
    for (int i = 0; i < 10; i++) begin
      start_b = (i == 3);
      @(negedge clk);
      check("b_hold", {tt_b[126:0], tt_valid_b}, {held[126:0], 1'b1});
    end
    tt_ready_b = 1'b1; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; tt_ready_b = 1'b0;
    check("b_accept", {125'(0), busy_b, tt_valid_b, |x_b}, 128'(0));
    @(negedge clk);
    check("b_no_queue", {126'(0), busy_b, tt_valid_b}, 128'(0));
    check("b_tt_kept", tt_b, 128'h5555555555555555aaaaaaaaaaaaaaaa);

    // small width on instance C
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    n = 0;
    while (!tt_valid_c && n < 200) begin
      @(negedge clk); n++;
    end
    check("c_latency", 128'(n), 128'(8));
    check("c_tt", 128'(tt_c), 128'(8'h88));
`ifdef TT_POPCOUNT_EN
    check("c_ones", 128'(ones_c), 128'(2));
`endif
    @(negedge clk);
    check("c_released", {126'(0), busy_c, tt_valid_c}, 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
